bcd_counter_n: RTL and testbench
================================

# bcd_counter_n

Parametrised N-digit BCD up/down counter. It is the successor to the fixed three-digit, increment-only BCD counter. It adds:
- selectable digit count;
- decrement and parallel load with validity check;
- wrap or saturate mode at the range limits;
- registered divisibility flags (fizz = ÷3, buzz = ÷5) for the FizzBuzz display path.

It sits between the event/tick source and the digit-to-segment/UART formatting logic.

## Interface
- `DIGITS`, default 3: number of BCD digits, valid range 1..8. Count range is 0 .. 10^DIGITS−1.
- `SATURATE`, default 0: selects range-limit behaviour.
  - 0: wrap (max+1→0, 0−1→max).
  - 1: hold at limit.
- `clk`  input  1: system clock, all logic on rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `increment`  input  1: count up by one this cycle.
- `decrement`  input  1: count down by one this cycle.
- `load`  input  1: load `load_value` this cycle.
- `load_value`  input  4*DIGITS: BCD value to load; digit k occupies bits [4k+3:4k], digit 0 least significant.
- `count`  output  4*DIGITS: current BCD value, same packing as `load_value`.
- `carry`  output  1: one-cycle pulse, count wrapped max→0 (wrap mode only).
- `borrow`  output  1: one-cycle pulse, count wrapped 0→max (wrap mode only).
- `at_max`  output  1: count == all digits 9.
- `at_zero`  output  1: count == 0.
- `fizz`  output  1: count divisible by 3 (0 counts as divisible).
- `buzz`  output  1: count divisible by 5.
- `load_err`  output  1: one-cycle pulse, a load was rejected.

## Operation
- Per-cycle command priority, highest first:
  1. `rst`.
  2. `load`.
  3. `increment` XOR `decrement`.
  4. Hold.
- `increment` and `decrement` both high with no load: hold; no pulses.
- Load:
  - If every digit of `load_value` is ≤9, `count` ← `load_value`.
  - If any digit is ≥10, `count` is unchanged and `load_err` pulses.
  - `carry` and `borrow` never pulse on a load.
- Increment: digit 0 +1. A digit at 9 becomes 0 and carries into the next digit. A carry out of the top digit is the wrap case.
- Decrement: digit 0 −1. A digit at 0 becomes 9 and borrows from the next digit. A borrow out of the top digit is the wrap case.
- Wrap mode (`SATURATE`=0):
  - Increment at max → 0, with `carry` pulse.
  - Decrement at 0 → max, with `borrow` pulse.
- Saturate mode (`SATURATE`=1):
  - Increment at max → no change.
  - Decrement at 0 → no change.
  - `carry` and `borrow` stay 0.
- `fizz`: derived from the next-state count, using (sum of digits) mod 3 == 0.
- `buzz`: derived from the next-state digit 0 ∈ {0,5}.
- Flags and pulses are registered and always describe the value currently on `count`.
- Outputs must never show a non-BCD digit.

## Timing
- Reset values, all applied on the first clock edge with `rst` high:
  - `count` = 0.
  - `at_zero` = 1, `fizz` = 1, `buzz` = 1.
  - `at_max` = 0; for DIGITS≥1 zero ≠ max.
  - `carry`, `borrow`, `load_err` = 0.
- Latency: a command sampled at edge n is reflected on all outputs immediately after edge n. No combinational input→output paths.
- `carry` and `borrow` are high for exactly the one cycle in which `count` first shows the wrapped value.
- `load_err` is high for the one cycle following the rejected load.
- Back-to-back commands on consecutive cycles are each honoured; no dead cycles.
- `rst` mid-operation overrides any concurrent load or count command. Pending pulses are cleared on that edge.
- Inputs are synchronous to `clk`. Edge detection of external events is the caller's job: a held `increment` counts every cycle.

## Test plan
- Reset, then 120 single-cycle `increment` pulses (DIGITS=3, SATURATE=0):
  - `count` ends at 0x120.
  - `fizz` is high at 3, 6, … 120; `buzz` is high at 5, 10, … 120.
  - Both are high at 15, 30, … 120.
- Load 0x998, then increment ×2 (wrap mode):
  - `count` = 0x999 with `at_max`=1.
  - Then `count` = 0x000, with `carry`=1 for one cycle and `at_zero`=1.
- From 0x000, decrement (wrap mode): `count` = 0x999, `borrow` pulses once. With SATURATE=1: `count` stays 0x000 and `borrow` stays 0.
- Load 0x1A3: `count` unchanged and `load_err` pulses one cycle. Then load 0x405: `count` = 0x405, `buzz`=1, `fizz`=1.
- `increment` and `decrement` both high for 3 cycles: `count` unchanged, no pulses. Then load and increment together with load_value 0x050: `count` = 0x050, not 0x051.
- Assert `rst` in the same cycle as `increment` at count 0x999: `count` = 0x000 and `carry` stays 0. DIGITS=1 build: increment ×10 from 0 gives 0x0 with a `carry` pulse.

Source files
------------

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with validated parallel load, wrap/saturate limits
// and registered divisibility flags (fizz = /3, buzz = /5) for the FizzBuzz display.
module bcd_counter_n #(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                increment,
  input  logic                decrement,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic                borrow,
  output logic                at_max,
  output logic                at_zero,
  output logic                fizz,
  output logic                buzz,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      count_q, count_d;
  logic [W-1:0]      inc_val, dec_val;
  logic [DIGITS:0]   inc_c, dec_b;
  logic [DIGITS-1:0] digit_ok, nxt_nine, nxt_zero;
  logic              carry_q, carry_d;
  logic              borrow_q, borrow_d;
  logic              load_err_q, load_err_d;
  logic              at_max_q, at_zero_q, fizz_q, buzz_q;
  logic [6:0]        digit_sum;

  assign inc_c[0] = 1'b1;
  assign dec_b[0] = 1'b1;

  // Ripple chains: the chain bit out of the top digit marks the range-limit case.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] cur;
    logic [3:0] nxt;
    assign cur = count_q[4*gi +: 4];
    assign nxt = count_d[4*gi +: 4];

    assign inc_val[4*gi +: 4] = !inc_c[gi] ? cur : ((cur == 4'd9) ? 4'd0 : cur + 4'd1);
    assign inc_c[gi+1]        = inc_c[gi] && (cur == 4'd9);
    assign dec_val[4*gi +: 4] = !dec_b[gi] ? cur : ((cur == 4'd0) ? 4'd9 : cur - 4'd1);
    assign dec_b[gi+1]        = dec_b[gi] && (cur == 4'd0);

    assign digit_ok[gi] = (load_value[4*gi +: 4] <= 4'd9);
    assign nxt_nine[gi] = (nxt == 4'd9);
    assign nxt_zero[gi] = (nxt == 4'd0);
  end

  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (&digit_ok) count_d = load_value;
      else           load_err_d = 1'b1;
    end else if (increment && !decrement) begin
      if (!inc_c[DIGITS]) begin
        count_d = inc_val;
      end else if (!SATURATE) begin
        count_d = inc_val;
        carry_d = 1'b1;
      end
    end else if (decrement && !increment) begin
      if (!dec_b[DIGITS]) begin
        count_d = dec_val;
      end else if (!SATURATE) begin
        count_d  = dec_val;
        borrow_d = 1'b1;
      end
    end
  end

  // Digit-sum test for /3: 10 = 1 (mod 3), so the sum of digits keeps the residue.
  always_comb begin
    digit_sum = 7'd0;
    for (int k = 0; k < DIGITS; k++) begin
      digit_sum = digit_sum + 7'(count_d[4*k +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      at_max_q   <= 1'b0;
      at_zero_q  <= 1'b1;
      fizz_q     <= 1'b1;
      buzz_q     <= 1'b1;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
      at_max_q   <= &nxt_nine;
      at_zero_q  <= &nxt_zero;
      fizz_q     <= ((digit_sum % 7'd3) == 7'd0);
      buzz_q     <= (count_d[3:0] == 4'd0) || (count_d[3:0] == 4'd5);
    end
  end

  assign count    = count_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign load_err = load_err_q;
  assign at_max   = at_max_q;
  assign at_zero  = at_zero_q;
  assign fizz     = fizz_q;
  assign buzz     = buzz_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboarded bench for bcd_counter_n: 3-digit wrap, 3-digit saturate and 1-digit wrap
// instances share stimulus; an integer model predicts every output after each edge.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        rst, increment, decrement, load;
  logic [11:0] lv;

  logic [11:0] cnt_a, cnt_s;
  logic [3:0]  cnt_o;
  logic [6:0]  fl_a, fl_s, fl_o;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int          id;
    logic [11:0] cnt;
    logic [6:0]  fl;
  } sb_t;
  sb_t sb_q[$];

  int st[3];
  int dg_of[3]  = '{3, 3, 1};
  bit sat_of[3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(3), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .increment(increment), .decrement(decrement), .load(load),
    .load_value(lv), .count(cnt_a), .carry(fl_a[6]), .borrow(fl_a[5]), .at_max(fl_a[4]),
    .at_zero(fl_a[3]), .fizz(fl_a[2]), .buzz(fl_a[1]), .load_err(fl_a[0]));

  bcd_counter_n #(.DIGITS(3), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .increment(increment), .decrement(decrement), .load(load),
    .load_value(lv), .count(cnt_s), .carry(fl_s[6]), .borrow(fl_s[5]), .at_max(fl_s[4]),
    .at_zero(fl_s[3]), .fizz(fl_s[2]), .buzz(fl_s[1]), .load_err(fl_s[0]));

  bcd_counter_n #(.DIGITS(1), .SATURATE(1'b0)) u_one (
    .clk(clk), .rst(rst), .increment(increment), .decrement(decrement), .load(load),
    .load_value(lv[3:0]), .count(cnt_o), .carry(fl_o[6]), .borrow(fl_o[5]), .at_max(fl_o[4]),
    .at_zero(fl_o[3]), .fizz(fl_o[2]), .buzz(fl_o[1]), .load_err(fl_o[0]));

  function automatic logic [11:0] to_bcd(input int val, input int d);
    logic [11:0] r = '0;
    int v = val;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Flags packed as {carry, borrow, at_max, at_zero, fizz, buzz, load_err}.
  function automatic void model(input int d, input bit sat, input int cur,
                                input bit r, input bit i, input bit dc, input bit l,
                                input logic [11:0] v, output int nxt, output logic [6:0] fl);
    int mx = 1;
    int lvd = 0;
    bit ok = 1'b1;
    bit c = 1'b0, b = 1'b0, e = 1'b0;
    for (int k = 0; k < d; k++) mx = mx * 10;
    mx = mx - 1;
    for (int k = d - 1; k >= 0; k--) begin
      int dg;
      dg = int'((v >> (4 * k)) & 12'hF);
      if (dg > 9) ok = 1'b0;
      lvd = lvd * 10 + dg;
    end
    nxt = cur;
    if (r) nxt = 0;
    else if (l) begin
      if (ok) nxt = lvd;
      else e = 1'b1;
    end else if (i && !dc) begin
      if (cur < mx) nxt = cur + 1;
      else if (!sat) begin nxt = 0; c = 1'b1; end
    end else if (dc && !i) begin
      if (cur > 0) nxt = cur - 1;
      else if (!sat) begin nxt = mx; b = 1'b1; end
    end
    fl = {c, b, nxt == mx, nxt == 0, (nxt % 3) == 0, (nxt % 5) == 0, e};
  endfunction

  function automatic logic [18:0] observe(input int id);
    case (id)
      0:       return {cnt_a, fl_a};
      1:       return {cnt_s, fl_s};
      default: return {8'h00, cnt_o, fl_o};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit i, input bit dc, input bit l, input logic [11:0] v);
    int nx;
    logic [6:0] f;
    sb_t e;
    logic [18:0] o;
    rst = r; increment = i; decrement = dc; load = l; lv = v;
    for (int id = 0; id < 3; id++) begin
      model(dg_of[id], sat_of[id], st[id], r, i, dc, l, v, nx, f);
      st[id] = nx;
      e.id = id; e.cnt = to_bcd(nx, dg_of[id]); e.fl = f;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = observe(e.id);
      n_assert++;
      assert (o[18:7] === e.cnt) else begin
        n_fail++;
        $error("FAIL count[%0d] observed=%h expected=%h", e.id, o[18:7], e.cnt);
      end
      n_assert++;
      assert (o[6:0] === e.fl) else begin
        n_fail++;
        $error("FAIL flags[%0d] observed=%b expected=%b", e.id, o[6:0], e.fl);
      end
    end
    $display("step rst=%0b inc=%0b dec=%0b ld=%0b lv=%h -> wrap=%h sat=%h one=%h",
             r, i, dc, l, v, cnt_a, cnt_s, cnt_o);
  endtask

  initial begin
    rst = 1'b1; increment = 1'b0; decrement = 1'b0; load = 1'b0; lv = '0;
    st[0] = 0; st[1] = 0; st[2] = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 0, 0, 12'h000);
    chk("reset_wrap", {cnt_a, fl_a}, {12'h000, 7'b0001110});

    // 120 single-cycle increment pulses
    for (int n = 0; n < 120; n++) begin
      step(0, 1, 0, 0, 12'h000);
      step(0, 0, 0, 0, 12'h000);
    end
    chk("count_120", {7'd0, cnt_a}, {7'd0, 12'h120});
    chk("fizzbuzz_120", {17'd0, fl_a[2:1]}, {17'd0, 2'b11});

    // wrap at max
    step(0, 0, 0, 1, 12'h998);
    step(0, 1, 0, 0, 12'h000);
    chk("at_max_999", {cnt_a, fl_a[4]}, {12'h999, 1'b1});
    step(0, 1, 0, 0, 12'h000);
    chk("carry_wrap", {cnt_a, fl_a[6], fl_a[3]}, {12'h000, 1'b1, 1'b1});
    chk("sat_hold_max", {cnt_s, fl_s[6]}, {12'h999, 1'b0});
    step(0, 0, 0, 0, 12'h000);
    chk("carry_one_cycle", {18'd0, fl_a[6]}, {18'd0, 1'b0});

    // wrap/saturate at zero
    step(0, 0, 0, 1, 12'h000);
    step(0, 0, 1, 0, 12'h000);
    chk("borrow_wrap", {cnt_a, fl_a[5]}, {12'h999, 1'b1});
    chk("sat_hold_zero", {cnt_s, fl_s[5]}, {12'h000, 1'b0});

    // rejected then accepted load
    step(0, 0, 0, 1, 12'h1A3);
    chk("load_err", {cnt_a, fl_a[0]}, {12'h999, 1'b1});
    step(0, 0, 0, 1, 12'h405);
    chk("load_405", {cnt_a, fl_a[2:0]}, {12'h405, 3'b110});

    // inc and dec together hold; load beats increment
    repeat (3) step(0, 1, 1, 0, 12'h000);
    chk("both_hold", {cnt_a, fl_a[6:5]}, {12'h405, 2'b00});
    step(0, 1, 0, 1, 12'h050);
    chk("load_over_inc", {7'd0, cnt_a}, {7'd0, 12'h050});

    // reset beats increment at max
    step(0, 0, 0, 1, 12'h999);
    step(1, 1, 0, 0, 12'h000);
    chk("rst_over_inc", {cnt_a, fl_a[6]}, {12'h000, 1'b0});

    // one-digit build: ten increments wrap to 0 with carry
    for (int n = 0; n < 10; n++) step(0, 1, 0, 0, 12'h000);
    chk("one_digit_wrap", {cnt_o, fl_o[6]}, {4'h0, 1'b1});

    // randomised command mix, back-to-back
    for (int n = 0; n < 300; n++) begin
      logic [11:0] rv;
      rv = 12'($urandom);
      if ($urandom_range(0, 3) != 0) rv = to_bcd(int'($urandom_range(0, 999)), 3);
      step($urandom_range(0, 40) == 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 7) == 0, rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
